// File: rtl/layers_seq.sv
// layers_seq: frames a raw image-beat stream into accumulation windows for `layers`
// and counts result handshakes per tile. Optional watchdog: LAYERS_SEQ_TIMEOUT_EN.
module layers_seq #(
  parameter int                    CFG_DWIDTH = 32,
  parameter int                    CFG_AWIDTH = 5,
  parameter int                    GROUP_NB   = 4,
  parameter int                    IMG_WIDTH  = 16,
  parameter logic [CFG_AWIDTH-1:0] CFG_SEQ_A  = 5'd20,
  parameter logic [CFG_AWIDTH-1:0] CFG_SEQ_B  = 5'd21
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic [GROUP_NB*IMG_WIDTH-1:0] src_bus,
  input  logic                          src_val,
  output logic                          src_rdy,
  output logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
  output logic                          image_last,
  output logic                          image_val,
  input  logic                          image_rdy,
  input  logic                          result_val,
  input  logic                          result_rdy
`ifdef LAYERS_SEQ_TIMEOUT_EN
  ,
  output logic                          timeout
`endif
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_STREAM = 4'b0010,
    S_DRAIN  = 4'b0100,
    S_DONE   = 4'b1000
  } state_t;

  state_t      r_state;
  logic [15:0] r_steps, r_outputs;
  logic [7:0]  r_pool_nb;
  logic [15:0] r_sh_steps, r_sh_outputs;
  logic [7:0]  r_sh_pool_nb;
  logic [15:0] r_beat_cnt, r_sched_cnt, r_res_cnt;
  logic [7:0]  r_win_cnt;

  logic        w_stream, w_active, w_beat, w_res, w_last;
  logic [15:0] w_last_idx, w_res_next;
  logic        w_unused;

  assign w_unused = ^cfg_data[CFG_DWIDTH-1:24];

  always_ff @(posedge clk) begin
    if (cfg_valid && cfg_addr == CFG_SEQ_A) begin
      r_steps   <= cfg_data[15:0];
      r_pool_nb <= cfg_data[23:16];
    end
    if (cfg_valid && cfg_addr == CFG_SEQ_B) begin
      r_outputs <= cfg_data[15:0];
    end
  end

  assign w_stream   = (r_state == S_STREAM);
  assign w_active   = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign image_bus  = src_bus;
  assign image_val  = src_val & w_stream;
  assign src_rdy    = image_rdy & w_stream;
  assign w_beat     = src_val & image_rdy & w_stream;
  assign w_res      = result_val & result_rdy & w_active;
  assign w_last_idx = (r_sh_steps == '0) ? '0 : r_sh_steps - 16'd1;
  assign w_last     = w_stream && (r_beat_cnt == w_last_idx);
  assign image_last = w_last;
  // DRAIN exits on the handshake itself so DONE lands one cycle after it.
  assign w_res_next = r_res_cnt + {15'd0, w_res};
  assign busy       = w_active;
  assign done       = (r_state == S_DONE);

`ifdef LAYERS_SEQ_TIMEOUT_EN
  logic [23:0] r_wdog;
  logic        r_timeout;
  assign timeout = r_timeout;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sh_steps   <= '0;
      r_sh_outputs <= '0;
      r_sh_pool_nb <= '0;
      r_beat_cnt   <= '0;
      r_sched_cnt  <= '0;
      r_res_cnt    <= '0;
      r_win_cnt    <= '0;
`ifdef LAYERS_SEQ_TIMEOUT_EN
      r_wdog       <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sh_steps   <= r_steps;
            r_sh_outputs <= r_outputs;
            r_sh_pool_nb <= r_pool_nb;
            r_beat_cnt   <= '0;
            r_sched_cnt  <= '0;
            r_res_cnt    <= '0;
            r_win_cnt    <= '0;
            r_state      <= (r_outputs == '0) ? S_DONE : S_STREAM;
`ifdef LAYERS_SEQ_TIMEOUT_EN
            r_wdog       <= '0;
            r_timeout    <= 1'b0;
`endif
          end
        end
        S_STREAM: begin
          if (w_beat) begin
            if (w_last) begin
              r_beat_cnt <= '0;
              if (r_win_cnt == r_sh_pool_nb) begin
                r_win_cnt   <= '0;
                r_sched_cnt <= r_sched_cnt + 16'd1;
                if (r_sched_cnt + 16'd1 == r_sh_outputs) r_state <= S_DRAIN;
              end else begin
                r_win_cnt <= r_win_cnt + 8'd1;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + 16'd1;
            end
          end
        end
        S_DRAIN: begin
          if (w_res_next == r_sh_outputs) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_res) r_res_cnt <= w_res_next;

`ifdef LAYERS_SEQ_TIMEOUT_EN
      if (w_active) begin
        if (w_beat || w_res) begin
          r_wdog <= '0;
        end else if (r_wdog == '1) begin
          r_wdog    <= '0;
          r_timeout <= 1'b1;
          r_state   <= S_DONE;
        end else begin
          r_wdog <= r_wdog + 24'd1;
        end
      end
`endif
    end
  end

endmodule
